hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
Parametrised successor to the pipeline forwarding unit. It generates EX-stage and ID-branch operand forward selects, plus ID stall / EX bubble requests for load-use, branch-in-ID and multi-cycle multiply hazards. A registered scoreboard tracks the one in-flight multi-cycle multiply and emits its write-back pulse. Sits beside the pipeline registers, between decode control and the operand muxes.

Parameters:
REG_AW, 3, register address width (2**REG_AW architectural registers; register 0 hard-wired zero, never forwarded or stalled on)
MUL_LAT, 3, multiply latency in cycles from issue in EX to write-back pulse; legal range 2..15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rs1ID, rs2ID  in  REG_AW  source registers of instruction in ID
usesRs1ID, usesRs2ID  in  1  ID instruction actually reads rs1/rs2
isBranchID  in  1  ID instruction is a branch compared in ID
isMulID  in  1  ID instruction is a multi-cycle multiply
rs1EX, rs2EX, rdEX  in  REG_AW  EX-stage register fields
RegWriteEX, MemReadEX  in  1  EX writes rd / EX is a load
mulIssue  in  1  EX holds a valid (unflushed) multiply this cycle
rdMEM  in  REG_AW; RegWriteMEM, MemReadMEM  in  1  MEM-stage fields
rdWB  in  REG_AW; RegWriteWB  in  1  WB-stage fields
fwd1EX, fwd2EX  out  2  EX operand select: 0=MEM, 1=WB, 2=regfile
Bfwd1, Bfwd2  out  2  ID branch operand select, same encoding
stallID  out  1  hold PC and IF/ID this cycle
flushEX  out  1  insert bubble into ID/EX this cycle (equals stallID)
mulBusy  out  1  multiply in flight
mulRd  out  REG_AW  destination of in-flight multiply
mulWB  out  1  write multiply result to mulRd this cycle (regfile second write port)
stallCount  out  16  stall cycle counter (see Optional Feature)

Behaviour:
- Forward selects are combinational. fwdNEX=0 if rsNEX==rdMEM & RegWriteMEM & rsNEX!=0; else 1 if rsNEX==rdWB & RegWriteWB & rsNEX!=0; else 2. MEM has priority over WB.
- BfwdN uses the same rule on rsNID, MEM over WB.
- Match term mN = usesRsNID & rsNID!=0 & rsNID==X, for any register X.
- stallID asserted combinationally when any of:
  a) load-use: MemReadEX & RegWriteEX & (m1|m2 against rdEX);
  b) branch on EX producer: isBranchID & RegWriteEX & (m1|m2 against rdEX);
  c) branch on MEM load: isBranchID & MemReadMEM & RegWriteMEM & (m1|m2 against rdMEM);
  d) RAW on multiply: (mulBusy & m against mulRd) | (mulIssue & m against rdEX);
  e) structural: isMulID & (mulBusy | mulIssue).
- Scoreboard registers: mulBusy, mulRd, cnt (width $clog2(MUL_LAT+1)).
  - On mulIssue: mulBusy<=1, mulRd<=rdEX, cnt<=MUL_LAT-1.
  - While mulBusy & cnt!=0: cnt decrements.
  - When mulBusy & cnt==0: WB cycle; mulBusy<=0 next edge.
  - mulIssue while mulBusy is impossible because of rule e; if it occurs, the new issue overwrites and the old result is dropped.
- mulWB = mulBusy & cnt==0 & mulRd!=0 & !(RegWriteWB & rdWB==mulRd). The younger WB write wins the WAW conflict, and the multiply write is suppressed.
- Issue on edge k → mulWB high for exactly the single cycle k+MUL_LAT-1 after that edge; the total span from issue cycle to WB is MUL_LAT cycles.
- Reset (asynchronous, any time, including mid-multiply): mulBusy=0, mulRd=0, cnt=0, stallCount=0. No mulWB is emitted after reset.
- With all write enables low, outputs are fwd*=2, Bfwd*=2, stallID=flushEX=0, mulWB=0.

Optional Feature:
HAZ_STALL_CNT_EN
- Defined: stallCount increments on every clock with stallID=1 and saturates at 16'hFFFF. Cleared only by reset.
- Undefined: stallCount is tied to 0 and the counter register is not built.

Test Plan:
1. rs1EX=3, rdMEM=3, RegWriteMEM=1, rdWB=3, RegWriteWB=1 → fwd1EX=0. Drop RegWriteMEM → fwd1EX=1. rs1EX=0 → fwd1EX=2.
2. Load in EX with rdEX=5, MemReadEX=RegWriteEX=1, ID rs2ID=5, usesRs2ID=1 → stallID=flushEX=1 for that cycle. With usesRs2ID=0 → no stall.
3. Branch in ID, rs1ID=4, RegWriteEX=1, rdEX=4 → stall. Next cycle producer in MEM (non-load) → no stall, Bfwd1=0.
4. MUL_LAT=3, mulIssue with rdEX=6 → mulBusy=1 for 3 cycles, mulWB high only in the 3rd. ID reading r6 stalls through that cycle. isMulID stalls while busy.
5. mulWB cycle with RegWriteWB=1, rdWB=mulRd → mulWB=0 and mulBusy clears next edge. Also: rst_n pulsed low mid-multiply → mulBusy=0 immediately, and no mulWB follows.
6. HAZ_STALL_CNT_EN defined, 4 stall cycles → stallCount=4. Saturation check from 16'hFFFE. Macro undefined → stallCount stays 0.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Operand forward selects for EX and ID-branch compares, ID stall / EX bubble
// generation for load-use, branch-in-ID and multi-cycle multiply hazards, and a
// one-entry scoreboard for the in-flight multiply with its write-back pulse.
// Optional build macro: HAZ_STALL_CNT_EN builds a saturating stall-cycle counter
// on stallCount; without it stallCount is constant zero.
module hazard_forward_unit #(
    parameter int REG_AW  = 3,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1ID,
    input  logic [REG_AW-1:0] rs2ID,
    input  logic              usesRs1ID,
    input  logic              usesRs2ID,
    input  logic              isBranchID,
    input  logic              isMulID,
    input  logic [REG_AW-1:0] rs1EX,
    input  logic [REG_AW-1:0] rs2EX,
    input  logic [REG_AW-1:0] rdEX,
    input  logic              RegWriteEX,
    input  logic              MemReadEX,
    input  logic              mulIssue,
    input  logic [REG_AW-1:0] rdMEM,
    input  logic              RegWriteMEM,
    input  logic              MemReadMEM,
    input  logic [REG_AW-1:0] rdWB,
    input  logic              RegWriteWB,
    output logic [1:0]        fwd1EX,
    output logic [1:0]        fwd2EX,
    output logic [1:0]        Bfwd1,
    output logic [1:0]        Bfwd2,
    output logic              stallID,
    output logic              flushEX,
    output logic              mulBusy,
    output logic [REG_AW-1:0] mulRd,
    output logic              mulWB,
    output logic [15:0]       stallCount
);

    localparam int                 CNT_W    = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic              r_mul_busy;
    logic [REG_AW-1:0] r_mul_rd;
    logic [CNT_W-1:0]  r_cnt;

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_mul;
    logic w_load_use;
    logic w_br_ex;
    logic w_br_mem_ld;
    logic w_mul_raw;
    logic w_mul_struct;
    logic w_stall;

    // Select: 0 = MEM result, 1 = WB result, 2 = register file; MEM is younger so it wins.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_mem,
        input logic              we_mem,
        input logic [REG_AW-1:0] rd_wb,
        input logic              we_wb
    );
        logic [1:0] sel;
        sel = 2'd2;
        if (rs != '0 && we_mem && rs == rd_mem)
            sel = 2'd0;
        else if (rs != '0 && we_wb && rs == rd_wb)
            sel = 2'd1;
        return sel;
    endfunction

    // A source only creates a hazard if it is really read and is not r0.
    function automatic logic src_match(
        input logic              uses,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] x
    );
        return uses && (rs != '0) && (rs == x);
    endfunction

    // Forward selects for the EX operands and the ID branch comparator.
    always_comb begin
        fwd1EX = fwd_sel(rs1EX, rdMEM, RegWriteMEM, rdWB, RegWriteWB);
        fwd2EX = fwd_sel(rs2EX, rdMEM, RegWriteMEM, rdWB, RegWriteWB);
        Bfwd1  = fwd_sel(rs1ID, rdMEM, RegWriteMEM, rdWB, RegWriteWB);
        Bfwd2  = fwd_sel(rs2ID, rdMEM, RegWriteMEM, rdWB, RegWriteWB);
    end

    // Hazard detection: any ID source that cannot yet be supplied holds ID.
    always_comb begin
        w_hit_ex     = src_match(usesRs1ID, rs1ID, rdEX)     | src_match(usesRs2ID, rs2ID, rdEX);
        w_hit_mem    = src_match(usesRs1ID, rs1ID, rdMEM)    | src_match(usesRs2ID, rs2ID, rdMEM);
        w_hit_mul    = src_match(usesRs1ID, rs1ID, r_mul_rd) | src_match(usesRs2ID, rs2ID, r_mul_rd);
        w_load_use   = MemReadEX & RegWriteEX & w_hit_ex;
        w_br_ex      = isBranchID & RegWriteEX & w_hit_ex;
        w_br_mem_ld  = isBranchID & MemReadMEM & RegWriteMEM & w_hit_mem;
        w_mul_raw    = (r_mul_busy & w_hit_mul) | (mulIssue & w_hit_ex);
        w_mul_struct = isMulID & (r_mul_busy | mulIssue);
        w_stall      = w_load_use | w_br_ex | w_br_mem_ld | w_mul_raw | w_mul_struct;
    end

    assign stallID = w_stall;
    assign flushEX = w_stall;

    // Multiply scoreboard: a new issue always takes the entry; otherwise count down to the WB cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_busy <= 1'b0;
            r_mul_rd   <= '0;
            r_cnt      <= '0;
        end else if (mulIssue) begin
            r_mul_busy <= 1'b1;
            r_mul_rd   <= rdEX;
            r_cnt      <= CNT_INIT;
        end else if (r_mul_busy) begin
            if (r_cnt != '0)
                r_cnt <= r_cnt - CNT_ONE;
            else
                r_mul_busy <= 1'b0;
        end
    end

    assign mulBusy = r_mul_busy;
    assign mulRd   = r_mul_rd;
    // A same-cycle WB write to the same register is younger, so the multiply write yields.
    assign mulWB   = r_mul_busy && (r_cnt == '0) && (r_mul_rd != '0) &&
                     !(RegWriteWB && (rdWB == r_mul_rd));

`ifdef HAZ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= 16'd0;
        else if (w_stall && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stallCount = r_stall_cnt;
`else
    assign stallCount = 16'd0;
`endif

endmodule
